// File: rtl/command_regs_pkg.sv
// Shared access-mode encoding and per-register mode selection for the
// command register bank.
package command_regs_pkg;

  typedef enum logic [1:0] {
    ACC_RW    = 2'd0,
    ACC_RO    = 2'd1,
    ACC_W1C   = 2'd2,
    ACC_PULSE = 2'd3
  } acc_t;

  localparam int ERR_COUNT_WIDTH = 8;

  // Masks are zero-extended to this width so one function serves any DEPTH.
  localparam int MAX_DEPTH = 1024;

  function automatic acc_t acc_mode(
    input logic [9:0]           n,
    input logic [MAX_DEPTH-1:0] ro_mask,
    input logic [MAX_DEPTH-1:0] w1c_mask,
    input logic [MAX_DEPTH-1:0] pulse_mask
  );
    acc_t mode;
    if (ro_mask[n]) begin
      mode = ACC_RO;
    end else if (w1c_mask[n]) begin
      mode = ACC_W1C;
    end else if (pulse_mask[n]) begin
      mode = ACC_PULSE;
    end else begin
      mode = ACC_RW;
    end
    return mode;
  endfunction

endpackage

// File: rtl/register_cell.sv
// One register of the bank; its access mode is fixed at elaboration time.
module register_cell
  import command_regs_pkg::*;
#(
  parameter int            W           = 32,
  parameter acc_t          MODE        = ACC_RW,
  parameter logic [W-1:0]  RESET_VALUE = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         w_hit,
  input  logic [W-1:0] w_value,
  input  logic [W-1:0] set_bits,
  input  logic [W-1:0] status,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] INIT_VALUE = (MODE == ACC_RW) ? RESET_VALUE : {W{1'b0}};

  logic [W-1:0] value_r;
  logic [W-1:0] next_s;
  logic [W-1:0] clr_s;

  // Next-state selection; for W1C the set term is OR-ed last so set beats clear.
  always_comb begin
    clr_s = w_hit ? w_value : {W{1'b0}};
    case (MODE)
      ACC_RW:    next_s = w_hit ? w_value : value_r;
      ACC_RO:    next_s = status;
      ACC_W1C:   next_s = (value_r & ~clr_s) | set_bits;
      ACC_PULSE: next_s = w_hit ? w_value : {W{1'b0}};
      default:   next_s = value_r;
    endcase
  end

  // Register state with asynchronous reset.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      value_r <= INIT_VALUE;
    end else begin
      value_r <= next_s;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/command_register_bank.sv
// Register bank behind the UART command parser: address decode, per-register
// cells, registered read path and illegal-access detection/counting.
module command_register_bank
  import command_regs_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int DEPTH      = 16,
  parameter logic [DEPTH-1:0] RO_MASK    = {DEPTH{1'b0}},
  parameter logic [DEPTH-1:0] W1C_MASK   = {DEPTH{1'b0}},
  parameter logic [DEPTH-1:0] PULSE_MASK = {DEPTH{1'b0}},
  parameter logic [REG_WIDTH*WORD_WIDTH-1:0] RESET_VALUE = {(REG_WIDTH*WORD_WIDTH){1'b0}}
) (
  input  logic                                       clk,
  input  logic                                       i_reset,
  input  logic                                       i_w_en,
  input  logic [WORD_WIDTH-1:0]                      i_w_addr,
  input  logic [REG_WIDTH*WORD_WIDTH-1:0]            i_w_value,
  input  logic                                       i_r_en,
  input  logic [WORD_WIDTH-1:0]                      i_r_addr,
  input  logic [DEPTH*REG_WIDTH*WORD_WIDTH-1:0]      i_status,
  input  logic [DEPTH*REG_WIDTH*WORD_WIDTH-1:0]      i_set,
  output logic [REG_WIDTH*WORD_WIDTH-1:0]            o_r_value,
  output logic                                       o_r_valid,
  output logic [DEPTH*REG_WIDTH*WORD_WIDTH-1:0]      o_regs,
  output logic                                       o_err,
  output logic [ERR_COUNT_WIDTH-1:0]                 o_err_count
);

  localparam int W  = REG_WIDTH * WORD_WIDTH;
  localparam int CW = ERR_COUNT_WIDTH;
  // One extra bit so DEPTH == 2**WORD_WIDTH still compares correctly.
  localparam logic [WORD_WIDTH:0] DEPTH_LIMIT = (WORD_WIDTH + 1)'(DEPTH);
  localparam logic [CW-1:0]       COUNT_MAX   = {CW{1'b1}};

  logic [W-1:0]     reg_value_s [DEPTH];
  logic [DEPTH-1:0] w_hit_s;
  logic [DEPTH-1:0] w_ro_hit_s;
  logic [DEPTH-1:0] r_sel_s;
  logic             w_in_range_s;
  logic             r_in_range_s;
  logic             err_s;
  logic [W-1:0]     r_data_s;

  logic [W-1:0]     r_value_r;
  logic             r_valid_r;
  logic             err_r;
  logic [CW-1:0]    err_count_r;

  assign w_in_range_s = ({1'b0, i_w_addr} < DEPTH_LIMIT);
  assign r_in_range_s = ({1'b0, i_r_addr} < DEPTH_LIMIT);

  for (genvar n = 0; n < DEPTH; n++) begin : g_reg
    localparam acc_t MODE_N = acc_mode(10'(n), MAX_DEPTH'(RO_MASK),
                                       MAX_DEPTH'(W1C_MASK), MAX_DEPTH'(PULSE_MASK));
    localparam logic [WORD_WIDTH-1:0] ADDR_N = WORD_WIDTH'(n);

    logic w_match_s;

    assign w_match_s     = (i_w_addr == ADDR_N);
    assign w_hit_s[n]    = i_w_en && w_match_s && (MODE_N != ACC_RO);
    assign w_ro_hit_s[n] = i_w_en && w_match_s && (MODE_N == ACC_RO);
    assign r_sel_s[n]    = (i_r_addr == ADDR_N);

    register_cell #(
      .W           (W),
      .MODE        (MODE_N),
      .RESET_VALUE (RESET_VALUE)
    ) u_cell (
      .clk      (clk),
      .i_reset  (i_reset),
      .w_hit    (w_hit_s[n]),
      .w_value  (i_w_value),
      .set_bits (i_set[n*W +: W]),
      .status   (i_status[n*W +: W]),
      .value    (reg_value_s[n])
    );

    assign o_regs[n*W +: W] = reg_value_s[n];
  end

  // AND-OR read mux; an out-of-range address selects nothing and yields 0.
  always_comb begin
    r_data_s = {W{1'b0}};
    for (int n = 0; n < DEPTH; n++) begin
      r_data_s = r_data_s | ({W{r_sel_s[n]}} & reg_value_s[n]);
    end
  end

  // An illegal write and an illegal read in the same cycle are one event.
  assign err_s = (i_w_en && (!w_in_range_s || (|w_ro_hit_s))) ||
                 (i_r_en && !r_in_range_s);

  // Read response register, error pulse and saturating error counter.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_value_r   <= {W{1'b0}};
      r_valid_r   <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= {CW{1'b0}};
    end else begin
      r_valid_r <= i_r_en;
      err_r     <= err_s;
      if (i_r_en) begin
        r_value_r <= r_data_s;
      end
      if (err_s && (err_count_r != COUNT_MAX)) begin
        err_count_r <= err_count_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_r_value   = r_value_r;
  assign o_r_valid   = r_valid_r;
  assign o_err       = err_r;
  assign o_err_count = err_count_r;

endmodule

// File: tb/tb_command_register_bank.sv
// Directed self-checking bench for command_register_bank: RO at 1, W1C at 5,
// PULSE at 7, every other register RW with a non-zero reset value.
module tb_command_register_bank;

  localparam int WW = 8;
  localparam int RW = 4;
  localparam int D  = 16;
  localparam int W  = 32;
  localparam logic [W-1:0] RST_VAL = 32'h0BAD_F00D;
  localparam logic [W-1:0] STAT1_A = 32'h1357_9BDF;
  localparam logic [W-1:0] STAT1_B = 32'h2468_ACE0;

  logic           clk = 1'b0;
  logic           i_reset;
  logic           i_w_en;
  logic [WW-1:0]  i_w_addr;
  logic [W-1:0]   i_w_value;
  logic           i_r_en;
  logic [WW-1:0]  i_r_addr;
  logic [D*W-1:0] i_status;
  logic [D*W-1:0] i_set;
  logic [W-1:0]   o_r_value;
  logic           o_r_valid;
  logic [D*W-1:0] o_regs;
  logic           o_err;
  logic [7:0]     o_err_count;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_r [D];

  command_register_bank #(
    .WORD_WIDTH  (WW),
    .REG_WIDTH   (RW),
    .DEPTH       (D),
    .RO_MASK     (16'h0002),
    .W1C_MASK    (16'h0020),
    .PULSE_MASK  (16'h0080),
    .RESET_VALUE (RST_VAL)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_w_en      (i_w_en),
    .i_w_addr    (i_w_addr),
    .i_w_value   (i_w_value),
    .i_r_en      (i_r_en),
    .i_r_addr    (i_r_addr),
    .i_status    (i_status),
    .i_set       (i_set),
    .o_r_value   (o_r_value),
    .o_r_valid   (o_r_valid),
    .o_regs      (o_regs),
    .o_err       (o_err),
    .o_err_count (o_err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D*W-1:0] exp_flat();
    logic [D*W-1:0] f;
    for (int n = 0; n < D; n++) f[n*W +: W] = exp_r[n];
    return f;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < D; n++) exp_r[n] = RST_VAL;
    exp_r[1] = i_status[1*W +: W];
    exp_r[5] = 32'h0;
    exp_r[7] = 32'h0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_w_en = 1'b0; i_r_en = 1'b0;
    i_w_addr = 8'd0; i_r_addr = 8'd0; i_w_value = 32'h0;
    i_set = '0; i_status = {16{STAT1_A}};
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_r_valid !== 1'b0 || o_err !== 1'b0 || o_err_count !== 8'd0 || o_r_value !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b err=%b cnt=%0d val=%h, want 0/0/0/0", o_r_valid, o_err, o_err_count, o_r_value); end
    checks++; if (o_regs[3*W +: W] !== RST_VAL || o_regs[1*W +: W] !== 32'h0 || o_regs[5*W +: W] !== 32'h0 || o_regs[7*W +: W] !== 32'h0) begin
      errors++; $display("FAIL reset_regs: got r3=%h r1=%h r5=%h r7=%h, want %h/0/0/0", o_regs[3*W +: W], o_regs[1*W +: W], o_regs[5*W +: W], o_regs[7*W +: W], RST_VAL); end
    i_reset = 1'b0;
    model_reset();
    tick();
    checks++; if (o_regs !== exp_flat()) begin
      errors++; $display("FAIL post_reset_regs: got %h want %h", o_regs, exp_flat()); end
    i_r_en = 1'b1; i_r_addr = 8'd3;
    tick();
    i_r_en = 1'b0;
    checks++; if (o_r_valid !== 1'b1 || o_r_value !== RST_VAL || o_err !== 1'b0) begin
      errors++; $display("FAIL reset_read3: got valid=%b val=%h err=%b, want 1/%h/0", o_r_valid, o_r_value, o_err, RST_VAL); end
    tick();
    checks++; if (o_r_valid !== 1'b0) begin
      errors++; $display("FAIL read_valid_pulse: got valid=%b want 0", o_r_valid); end
  endtask

  task automatic test_rw();
    i_w_en = 1'b1; i_w_addr = 8'd2; i_w_value = 32'hA5A5_1234;
    tick();
    i_w_en = 1'b0; exp_r[2] = 32'hA5A5_1234;
    checks++; if (o_regs !== exp_flat()) begin
      errors++; $display("FAIL rw_write: got %h want %h", o_regs, exp_flat()); end
    i_r_en = 1'b1; i_r_addr = 8'd2;
    tick();
    i_r_en = 1'b0;
    checks++; if (o_r_valid !== 1'b1 || o_r_value !== 32'hA5A5_1234) begin
      errors++; $display("FAIL rw_read: got valid=%b val=%h want 1/a5a51234", o_r_valid, o_r_value); end
    i_w_en = 1'b1; i_w_addr = 8'd2; i_w_value = 32'h1111_2222;
    i_r_en = 1'b1; i_r_addr = 8'd2;
    tick();
    i_w_en = 1'b0; i_r_en = 1'b0; exp_r[2] = 32'h1111_2222;
    checks++; if (o_r_value !== 32'hA5A5_1234) begin
      errors++; $display("FAIL rbw_read: got %h want a5a51234", o_r_value); end
    checks++; if (o_regs !== exp_flat()) begin
      errors++; $display("FAIL rbw_write: got %h want %h", o_regs, exp_flat()); end
    tick();
    checks++; if (o_r_valid !== 1'b0 || o_r_value !== 32'hA5A5_1234) begin
      errors++; $display("FAIL read_hold: got valid=%b val=%h want 0/a5a51234", o_r_valid, o_r_value); end
  endtask

  task automatic test_w1c();
    i_set[5*W +: W] = 32'h1;
    tick();
    i_set = '0;
    checks++; if (o_regs[5*W +: W] !== 32'h1) begin
      errors++; $display("FAIL w1c_set: got %h want 1", o_regs[5*W +: W]); end
    i_w_en = 1'b1; i_w_addr = 8'd5; i_w_value = 32'h1; i_set[5*W +: W] = 32'h1;
    tick();
    i_w_en = 1'b0; i_set = '0;
    checks++; if (o_regs[5*W +: W] !== 32'h1) begin
      errors++; $display("FAIL w1c_set_wins: got %h want 1", o_regs[5*W +: W]); end
    i_w_en = 1'b1; i_w_value = 32'h1;
    tick();
    i_w_en = 1'b0;
    checks++; if (o_regs[5*W +: W] !== 32'h0) begin
      errors++; $display("FAIL w1c_clear: got %h want 0", o_regs[5*W +: W]); end
    i_set[5*W +: W] = 32'h0000_00F0;
    tick();
    i_set = '0; i_w_en = 1'b1; i_w_addr = 8'd5; i_w_value = 32'h0000_0030;
    tick();
    i_w_en = 1'b0; exp_r[5] = 32'h0000_00C0;
    checks++; if (o_regs !== exp_flat()) begin
      errors++; $display("FAIL w1c_partial: got %h want %h", o_regs[5*W +: W], exp_r[5]); end
  endtask

  task automatic test_pulse();
    i_w_en = 1'b1; i_w_addr = 8'd7; i_w_value = 32'hFF;
    tick();
    i_w_en = 1'b0;
    checks++; if (o_regs[7*W +: W] !== 32'hFF) begin
      errors++; $display("FAIL pulse_live: got %h want ff", o_regs[7*W +: W]); end
    i_r_en = 1'b1; i_r_addr = 8'd7;
    tick();
    i_r_en = 1'b0;
    checks++; if (o_regs[7*W +: W] !== 32'h0 || o_r_value !== 32'hFF) begin
      errors++; $display("FAIL pulse_end: got reg=%h read=%h want 0/ff", o_regs[7*W +: W], o_r_value); end
    i_r_en = 1'b1;
    tick();
    i_r_en = 1'b0;
    checks++; if (o_r_value !== 32'h0) begin
      errors++; $display("FAIL pulse_idle_read: got %h want 0", o_r_value); end
    i_w_en = 1'b1; i_w_value = 32'hFF;
    tick();
    checks++; if (o_regs[7*W +: W] !== 32'hFF) begin
      errors++; $display("FAIL pulse_b2b_1: got %h want ff", o_regs[7*W +: W]); end
    tick();
    i_w_en = 1'b0;
    checks++; if (o_regs[7*W +: W] !== 32'hFF) begin
      errors++; $display("FAIL pulse_b2b_2: got %h want ff", o_regs[7*W +: W]); end
    tick();
    checks++; if (o_regs[7*W +: W] !== 32'h0) begin
      errors++; $display("FAIL pulse_b2b_end: got %h want 0", o_regs[7*W +: W]); end
  endtask

  task automatic test_illegal();
    i_w_en = 1'b1; i_w_addr = 8'd16; i_w_value = 32'hDEAD_BEEF;
    tick();
    i_w_en = 1'b0;
    checks++; if (o_err !== 1'b1 || o_err_count !== 8'd1) begin
      errors++; $display("FAIL ill_w16: got err=%b cnt=%0d want 1/1", o_err, o_err_count); end
    checks++; if (o_regs !== exp_flat()) begin
      errors++; $display("FAIL ill_w16_regs: got %h want %h", o_regs, exp_flat()); end
    tick();
    checks++; if (o_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got %b want 0", o_err); end
    i_w_en = 1'b1; i_w_addr = 8'd1; i_w_value = 32'h0;
    tick();
    i_w_en = 1'b0;
    checks++; if (o_err !== 1'b1 || o_err_count !== 8'd2 || o_regs[1*W +: W] !== STAT1_A) begin
      errors++; $display("FAIL ill_ro: got err=%b cnt=%0d r1=%h want 1/2/%h", o_err, o_err_count, o_regs[1*W +: W], STAT1_A); end
    i_status[1*W +: W] = STAT1_B;
    tick();
    exp_r[1] = STAT1_B;
    checks++; if (o_regs[1*W +: W] !== STAT1_B) begin
      errors++; $display("FAIL ro_track: got %h want %h", o_regs[1*W +: W], STAT1_B); end
    i_r_en = 1'b1; i_r_addr = 8'd1;
    tick();
    checks++; if (o_r_value !== STAT1_B || o_err !== 1'b0) begin
      errors++; $display("FAIL ro_read: got val=%h err=%b want %h/0", o_r_value, o_err, STAT1_B); end
    i_r_addr = 8'd200;
    tick();
    i_r_en = 1'b0;
    checks++; if (o_r_valid !== 1'b1 || o_r_value !== 32'h0 || o_err !== 1'b1 || o_err_count !== 8'd3) begin
      errors++; $display("FAIL ill_r200: got valid=%b val=%h err=%b cnt=%0d want 1/0/1/3", o_r_valid, o_r_value, o_err, o_err_count); end
    i_r_en = 1'b1; i_r_addr = 8'd16;
    tick();
    i_r_en = 1'b0;
    checks++; if (o_err_count !== 8'd4 || o_r_value !== 32'h0) begin
      errors++; $display("FAIL ill_r16: got cnt=%0d val=%h want 4/0", o_err_count, o_r_value); end
    i_w_en = 1'b1; i_w_addr = 8'd16; i_r_en = 1'b1; i_r_addr = 8'd255;
    tick();
    i_w_en = 1'b0; i_r_en = 1'b0;
    checks++; if (o_err !== 1'b1 || o_err_count !== 8'd5) begin
      errors++; $display("FAIL ill_both: got err=%b cnt=%0d want 1/5", o_err, o_err_count); end
    i_w_en = 1'b1; i_w_addr = 8'd15; i_w_value = 32'h0F0F_0F0F;
    tick();
    i_w_en = 1'b0; exp_r[15] = 32'h0F0F_0F0F;
    checks++; if (o_err !== 1'b0 || o_err_count !== 8'd5 || o_regs !== exp_flat()) begin
      errors++; $display("FAIL legal_w15: got err=%b cnt=%0d r15=%h want 0/5/0f0f0f0f", o_err, o_err_count, o_regs[15*W +: W]); end
  endtask

  task automatic test_saturation_and_reset();
    i_w_en = 1'b1; i_w_addr = 8'd16; i_w_value = 32'h1;
    repeat (299) tick();
    i_r_en = 1'b1; i_r_addr = 8'd2;
    tick();
    checks++; if (o_err_count !== 8'd255 || o_err !== 1'b1) begin
      errors++; $display("FAIL saturate: got cnt=%0d err=%b want 255/1", o_err_count, o_err); end
    checks++; if (o_r_valid !== 1'b1 || o_r_value !== 32'h1111_2222) begin
      errors++; $display("FAIL pre_reset_read: got valid=%b val=%h want 1/11112222", o_r_valid, o_r_value); end
    #2;
    i_reset = 1'b1;
    #1;
    checks++; if (o_err !== 1'b0 || o_err_count !== 8'd0 || o_r_valid !== 1'b0 || o_r_value !== 32'h0) begin
      errors++; $display("FAIL async_reset_out: got err=%b cnt=%0d valid=%b val=%h want 0/0/0/0", o_err, o_err_count, o_r_valid, o_r_value); end
    checks++; if (o_regs[2*W +: W] !== RST_VAL || o_regs[5*W +: W] !== 32'h0 || o_regs[1*W +: W] !== 32'h0) begin
      errors++; $display("FAIL async_reset_regs: got r2=%h r5=%h r1=%h want %h/0/0", o_regs[2*W +: W], o_regs[5*W +: W], o_regs[1*W +: W], RST_VAL); end
    i_w_en = 1'b0; i_r_en = 1'b0;
    tick();
    i_reset = 1'b0;
    model_reset();
    tick();
    checks++; if (o_regs !== exp_flat() || o_err_count !== 8'd0 || o_err !== 1'b0) begin
      errors++; $display("FAIL after_reset: got cnt=%0d err=%b regs=%h want 0/0/%h", o_err_count, o_err, o_regs, exp_flat()); end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_w1c();
    test_pulse();
    test_illegal();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/command_register_bank.md
# command_register_bank

Parameterised register bank that consumes the write/read strobes produced by the UART command parser and returns read data to its serializer/TX path. Each register has one of four access modes: read-write, read-only status, write-1-to-clear sticky, or self-clearing pulse. Register contents are exported flat to the rest of the design. Illegal accesses are flagged and counted.

## Interface
- `WORD_WIDTH`, 8, bits per word; address width.
- `REG_WIDTH`, 4, words per register; register width W = REG_WIDTH*WORD_WIDTH.
- `DEPTH`, 16, number of registers; legal addresses 0..DEPTH-1.
- `RO_MASK`, '0, DEPTH bits; bit n=1 makes register n read-only (value = i_status slice n).
- `W1C_MASK`, '0, DEPTH bits; bit n=1 makes register n sticky write-1-to-clear.
- `PULSE_MASK`, '0, DEPTH bits; bit n=1 makes register n self-clearing after one cycle.
- `RESET_VALUE`, '0, W bits; reset value of every RW register.
- `clk`  in  1  single clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_w_en`  in  1  write strobe, one-cycle pulse.
- `i_w_addr`  in  WORD_WIDTH  write address.
- `i_w_value`  in  W  write data.
- `i_r_en`  in  1  read strobe, one-cycle pulse.
- `i_r_addr`  in  WORD_WIDTH  read address.
- `i_status`  in  DEPTH*W  status inputs; slice n feeds RO register n.
- `i_set`  in  DEPTH*W  set bits for W1C registers; slice n feeds register n.
- `o_r_value`  out  W  read data.
- `o_r_valid`  out  1  read data valid, one-cycle pulse.
- `o_regs`  out  DEPTH*W  current register contents, with register n at slice [n*W +: W].
- `o_err`  out  1  one-cycle pulse on an illegal access.
- `o_err_count`  out  8  saturating count of illegal accesses.

## Operation
- Mode precedence, highest first: RO, then W1C, then PULSE. Any other register is RW.
- RW: on i_w_en with a matching address, the register loads i_w_value at the next edge.
- RO: writes are ignored and flagged illegal. o_regs slice n is i_status slice n, registered once.
- W1C: each cycle, reg <= (reg & ~clr) | i_set_n. clr is i_w_value when a write targets this register, otherwise 0. If set and clear hit the same bit in the same cycle, the set wins.
- PULSE: a write loads i_w_value for exactly one cycle, then the register returns to 0. Back-to-back writes give back-to-back pulses.
- Illegal access is any of:
  - write with i_w_addr >= DEPTH;
  - write to an RO register;
  - read with i_r_addr >= DEPTH.
- On an illegal access, o_err pulses and o_err_count increments, saturating at 255. An illegal write changes no register.
- An illegal read still returns o_r_valid with o_r_value = 0, so the host always gets a reply.
- A write and a read in the same cycle count as one event if both are illegal: o_err pulses once and the count adds 1.

## Timing
- Reset values:
  - RW registers = RESET_VALUE;
  - W1C, PULSE and RO registers = 0;
  - o_r_value = 0, o_r_valid = 0, o_err = 0, o_err_count = 0.
- Write latency is 1: the new value appears on o_regs at edge k+1 after i_w_en at edge k.
- Read latency is 1: o_r_valid is high for exactly the cycle after i_r_en. o_r_value updates on that same edge and holds until the next read.
- A read and a write to the same address in the same cycle return the pre-write value (read-before-write).
- Reading a PULSE register returns its current content, which is 0 except in the single cycle its pulse is live.
- Reads of RO registers return the registered i_status sample, one cycle old.
- Every address compare uses the full WORD_WIDTH, with no truncation.
- Reset asserted mid-operation clears all state immediately. It also drops any pending o_r_valid or o_err.

## Structure
- Package `command_regs_pkg` holds:
  - `typedef enum logic [1:0] {ACC_RW, ACC_RO, ACC_W1C, ACC_PULSE} acc_t`;
  - function `acc_mode(n, RO_MASK, W1C_MASK, PULSE_MASK)`, returning acc_t with the precedence above;
  - `ERR_COUNT_WIDTH = 8`.
- Sub-module `register_cell`, one per register, built by a generate loop:
  - parameters: acc_t mode and reset value;
  - inputs: write hit, data, i_set slice, i_status slice;
  - output: register value.
- The top level holds address decode, the read mux/register, error detection and the counter.

## Test plan
- Reset, then read address 3 with DEPTH=16 → o_r_valid one cycle later with o_r_value = RESET_VALUE; o_err stays 0.
- Write 0xA5A5_1234 to RW address 2, then read it on the next cycle → o_regs[2] = 0xA5A5_1234 after one edge; read returns 0xA5A5_1234. A simultaneous read and write to address 2 returns the old value.
- W1C at address 5: pulse i_set bit 0 → register = 0x1. Write 0x1 with i_set bit 0 held high in the same cycle → value stays 0x1. Write 0x1 after i_set is released → value = 0x0.
- PULSE at address 7: write 0xFF → o_regs[7] = 0xFF for exactly one cycle, then 0. Two consecutive writes give a two-cycle pulse.
- Illegal accesses:
  - write to address 16 → o_err pulse, count = 1, no register changes;
  - write to RO address 1 → count = 2, value still tracks i_status;
  - read address 200 → o_r_valid with value 0, count = 3.
- 300 illegal accesses → o_err_count saturates at 255. Assert i_reset mid-sequence → all outputs return to reset values asynchronously.
